des_key_schedule: RTL and testbench

//  Sequential DES key scheduler: accepts one 64-bit key, applies PC-1, then emits
//  NUM_ROUNDS 48-bit round subkeys, one per handshake, via C/D rotation + PC-2.

---
 rtl/des_key_schedule.sv | 179 +++++++++++++++++
 tb/tb_des_key_schedule.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// Sequential DES key scheduler.
// Loads one 64-bit key (PC-1 into C/D), then emits NUM_ROUNDS 48-bit subkeys
// (C/D rotation + PC-2), one per valid/ready handshake. Encrypt emits K1 upward,
// decrypt emits K16 downward by rotating right from C0D0 (== C16D16).
// Ports:
//   clk_i, rst_i       clock (rising edge), asynchronous active-high reset
//   key_i[64]          DES key, FIPS bit 1 = key_i[63]
//   key_valid_i/ready_o key load handshake; mode_i (0 enc, 1 dec) sampled with key
//   subkey_o[48]       current subkey, FIPS bit 1 = subkey_o[47]
//   subkey_valid_o/ready_i subkey handshake
//   round_o[4]         emission index of subkey_o, last_o marks the final subkey
//   parity_err_o       set on load when some key byte has even parity (CHECK_PARITY=1)
module des_key_schedule #(
  parameter int unsigned NUM_ROUNDS   = 16,
  parameter bit          CHECK_PARITY = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] key_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic        mode_i,
  output logic [47:0] subkey_o,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [3:0]  round_o,
  output logic        last_o,
  output logic        parity_err_o
);

  localparam int unsigned KEY_W   = 64;
  localparam int unsigned CD_W    = 56;
  localparam int unsigned HALF_W  = 28;
  localparam int unsigned SK_W    = 48;
  localparam int unsigned ROUND_W = 4;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  // Permutation tables in FIPS numbering (entry = 1-based source bit)
  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [SK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CD_W-1:0]      cd_q, cd_next;
  logic [ROUND_W-1:0]   round_q;
  logic                 mode_q;
  logic                 parity_err_q;
  logic [1:0]           shift_amt;
  logic                 load_key;
  logic                 advance;

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CD_W); i++) r[int'(CD_W) - 1 - i] = k[int'(KEY_W) - int'(PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SK_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(SK_W); i++) r[int'(SK_W) - 1 - i] = cd[int'(CD_W) - int'(PC2_TAB[i])];
    return r;
  endfunction

  // Rotate a 28-bit half by 0..2; right for decrypt, left for encrypt
  function automatic logic [HALF_W-1:0] rot(input logic [HALF_W-1:0] v,
                                            input logic [1:0] s,
                                            input logic right);
    logic [HALF_W-1:0] r;
    r = v;
    if (right) begin
      if (s == 2'd1)      r = {v[0], v[HALF_W-1:1]};
      else if (s == 2'd2) r = {v[1:0], v[HALF_W-1:2]};
    end else begin
      if (s == 2'd1)      r = {v[HALF_W-2:0], v[HALF_W-1]};
      else if (s == 2'd2) r = {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]};
    end
    return r;
  endfunction

  function automatic logic has_even_byte(input logic [KEY_W-1:0] k);
    logic r;
    r = 1'b0;
    for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) r = 1'b1;
    return r;
  endfunction

  // Shift schedule; decrypt round 0 emits K16 straight from C0D0
  always_comb begin
    shift_amt = 2'd2;
    if (mode_q) begin
      if (round_q == 4'd0)                          shift_amt = 2'd0;
      else if (round_q inside {4'd1, 4'd8, 4'd15})  shift_amt = 2'd1;
    end else if (round_q inside {4'd0, 4'd1, 4'd8, 4'd15}) begin
      shift_amt = 2'd1;
    end
  end

  assign cd_next = {rot(cd_q[CD_W-1:HALF_W], shift_amt, mode_q),
                    rot(cd_q[HALF_W-1:0],    shift_amt, mode_q)};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d  = state_q;
    load_key = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          load_key = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (subkey_ready_i) begin
          advance = 1'b1;
          if (round_q == LAST_ROUND) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Key datapath: load, then step C/D on each consumed subkey
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cd_q         <= '0;
      round_q      <= '0;
      mode_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else if (load_key) begin
      cd_q         <= pc1(key_i);
      round_q      <= '0;
      mode_q       <= mode_i;
      parity_err_q <= CHECK_PARITY & has_even_byte(key_i);
    end else if (advance) begin
      cd_q    <= cd_next;
      round_q <= (round_q == LAST_ROUND) ? '0 : round_q + ROUND_W'(1);
    end
  end

  assign key_ready_o    = (state_q == IDLE);
  assign subkey_valid_o = (state_q == RUN);
  assign subkey_o       = pc2(cd_next);
  assign round_o        = round_q;
  assign last_o         = (state_q == RUN) && (round_q == LAST_ROUND);
  assign parity_err_o   = parity_err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Testbench for des_key_schedule: a 16-round instance with parity checking and
// a 4-round instance without, compared against a textbook DES key-schedule model.
module tb_des_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 16-round instance, parity checking on
  logic [63:0] a_key;
  logic        a_kv, a_mode, a_sr;
  logic        a_kr, a_sv, a_last, a_perr;
  logic [47:0] a_sk;
  logic [3:0]  a_round;

  // 4-round instance, parity checking off
  logic [63:0] b_key;
  logic        b_kv, b_mode, b_sr;
  logic        b_kr, b_sv, b_last, b_perr;
  logic [47:0] b_sk;
  logic [3:0]  b_round;

  des_key_schedule #(.NUM_ROUNDS(16), .CHECK_PARITY(1'b1)) dut16 (
    .clk_i(clk), .rst_i(rst), .key_i(a_key), .key_valid_i(a_kv), .key_ready_o(a_kr),
    .mode_i(a_mode), .subkey_o(a_sk), .subkey_valid_o(a_sv), .subkey_ready_i(a_sr),
    .round_o(a_round), .last_o(a_last), .parity_err_o(a_perr)
  );

  des_key_schedule #(.NUM_ROUNDS(4), .CHECK_PARITY(1'b0)) dut4 (
    .clk_i(clk), .rst_i(rst), .key_i(b_key), .key_valid_i(b_kv), .key_ready_o(b_kr),
    .mode_i(b_mode), .subkey_o(b_sk), .subkey_valid_o(b_sv), .subkey_ready_i(b_sr),
    .round_o(b_round), .last_o(b_last), .parity_err_o(b_perr)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [47:0] ref_ks [16];
  logic [47:0] got_ks [16];

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Textbook schedule: C_n/D_n are C0/D0 rotated left by the cumulative shift count
  task automatic ref_schedule(input logic [63:0] key);
    int pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    bit c0 [28];
    bit d0 [28];
    int tot;
    int t;
    for (int j = 0; j < 28; j++) begin
      c0[j] = key[64 - pc1[j]];
      d0[j] = key[64 - pc1[28 + j]];
    end
    tot = 0;
    for (int n = 0; n < 16; n++) begin
      tot += sh[n];
      for (int i = 0; i < 48; i++) begin
        t = pc2[i];
        ref_ks[n][47 - i] = (t <= 28) ? c0[(t - 1 + tot) % 28] : d0[(t - 29 + tot) % 28];
      end
    end
  endtask

  function automatic bit even_byte(input logic [63:0] k);
    bit r = 1'b0;
    for (int b = 0; b < 8; b++) if (($countones(k[8*b +: 8]) % 2) == 0) r = 1'b1;
    return r;
  endfunction

  // Load one key into dut16 and consume stop_at subkeys (optionally with random stalls)
  task automatic run16(input logic [63:0] key, input bit mode, input bit stall,
                       input int stop_at, input string tag);
    int got;
    int cyc;
    bit rdy;
    bit stalled;
    logic [47:0] prev_sk;
    logic [3:0]  prev_rd;
    logic [47:0] exp_sk;
    ref_schedule(key);
    check($sformatf("%s_ready_idle", tag), 64'(a_kr), 64'(1));
    a_key = key; a_mode = mode; a_kv = 1'b1; a_sr = 1'b0;
    @(posedge clk); #1;
    a_kv = 1'b0;
    a_key = {$urandom, $urandom};
    a_mode = ~mode;
    check($sformatf("%s_perr", tag), 64'(a_perr), 64'(even_byte(key)));
    check($sformatf("%s_ready_run", tag), 64'(a_kr), 64'(0));
    got = 0; cyc = 0; stalled = 1'b0; prev_sk = '0; prev_rd = '0;
    while (got < stop_at && cyc < 400) begin
      exp_sk = mode ? ref_ks[15 - got] : ref_ks[got];
      check($sformatf("%s_r%0d_valid", tag, got), 64'(a_sv), 64'(1));
      check($sformatf("%s_r%0d_round", tag, got), 64'(a_round), 64'(got));
      check($sformatf("%s_r%0d_sk", tag, got), 64'(a_sk), 64'(exp_sk));
      check($sformatf("%s_r%0d_last", tag, got), 64'(a_last), 64'(got == 15));
      if (stalled) begin
        check($sformatf("%s_r%0d_hold_sk", tag, got), 64'(a_sk), 64'(prev_sk));
        check($sformatf("%s_r%0d_hold_rd", tag, got), 64'(a_round), 64'(prev_rd));
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      a_sr = rdy;
      prev_sk = a_sk; prev_rd = a_round;
      stalled = !rdy;
      if (rdy) got_ks[got] = a_sk;
      @(posedge clk); #1;
      if (rdy) got++;
      cyc++;
    end
    a_sr = 1'b0;
    check($sformatf("%s_handshakes", tag), 64'(got), 64'(stop_at));
    if (stop_at == 16) begin
      check($sformatf("%s_ready_after", tag), 64'(a_kr), 64'(1));
      check($sformatf("%s_valid_after", tag), 64'(a_sv), 64'(0));
    end
  endtask

  initial begin
    logic [47:0] exp_a [16];
    logic [63:0] key_b;
    logic [63:0] rkey;
    rst = 1'b0;
    a_key = '0; a_kv = 1'b0; a_mode = 1'b0; a_sr = 1'b0;
    b_key = '0; b_kv = 1'b0; b_mode = 1'b0; b_sr = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready16", 64'(a_kr), 64'(1));
    check("rst_valid16", 64'(a_sv), 64'(0));
    check("rst_round16", 64'(a_round), 64'(0));
    check("rst_last16", 64'(a_last), 64'(0));
    check("rst_perr16", 64'(a_perr), 64'(0));
    check("rst_ready4", 64'(b_kr), 64'(1));
    check("rst_valid4", 64'(b_sv), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer vector, encrypt then decrypt
    run16(KEY1, 1'b0, 1'b0, 16, "enc");
    check("enc_k1_const", 64'(got_ks[0]), 64'(K1));
    check("enc_k16_const", 64'(got_ks[15]), 64'(K16));
    run16(KEY1, 1'b1, 1'b0, 16, "dec");
    check("dec_first_const", 64'(got_ks[0]), 64'(K16));
    check("dec_last_const", 64'(got_ks[15]), 64'(K1));

    // Random backpressure
    run16(KEY1, 1'b0, 1'b1, 16, "bp");

    // Even-parity key still schedules; flag holds after the sequence
    run16(64'h0, 1'b0, 1'b0, 16, "zero");
    check("zero_sk_last", 64'(got_ks[15]), 64'(0));
    @(posedge clk); #1;
    check("zero_perr_hold", 64'(a_perr), 64'(1));

    // Random keys, both modes, random stalls
    for (int i = 0; i < 4; i++) begin
      rkey = {$urandom, $urandom};
      run16(rkey, 1'(i % 2), 1'b1, 16, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a sequence
    run16(KEY1, 1'b0, 1'b0, 7, "mid");
    check("mid_round7", 64'(a_round), 64'(7));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(a_sv), 64'(0));
    check("mid_rst_ready", 64'(a_kr), 64'(1));
    check("mid_rst_round", 64'(a_round), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_idle%0d", i), 64'(a_sv), 64'(0));
    end
    run16(KEY1, 1'b0, 1'b0, 16, "post_rst");

    // 4-round instance, key_valid held high across back-to-back keys
    ref_schedule(KEY1);
    for (int i = 0; i < 16; i++) exp_a[i] = ref_ks[i];
    key_b = {$urandom, $urandom};
    b_key = KEY1; b_mode = 1'b0; b_kv = 1'b1; b_sr = 1'b1;
    @(posedge clk); #1;
    b_key = key_b; b_mode = 1'b1;
    check("n4_perr_a", 64'(b_perr), 64'(0));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("n4a_r%0d_valid", i), 64'(b_sv), 64'(1));
      check($sformatf("n4a_r%0d_round", i), 64'(b_round), 64'(i));
      check($sformatf("n4a_r%0d_sk", i), 64'(b_sk), 64'(exp_a[i]));
      check($sformatf("n4a_r%0d_last", i), 64'(b_last), 64'(i == 3));
      @(posedge clk); #1;
    end
    check("n4_gap_ready", 64'(b_kr), 64'(1));
    check("n4_gap_valid", 64'(b_sv), 64'(0));
    @(posedge clk); #1;
    b_kv = 1'b0;
    ref_schedule(key_b);
    check("n4_perr_b", 64'(b_perr), 64'(0));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("n4b_r%0d_valid", i), 64'(b_sv), 64'(1));
      check($sformatf("n4b_r%0d_round", i), 64'(b_round), 64'(i));
      check($sformatf("n4b_r%0d_sk", i), 64'(b_sk), 64'(ref_ks[15 - i]));
      check($sformatf("n4b_r%0d_last", i), 64'(b_last), 64'(i == 3));
      @(posedge clk); #1;
    end
    check("n4_end_ready", 64'(b_kr), 64'(1));
    @(posedge clk); #1;
    check("n4_end_valid", 64'(b_sv), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
